// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit_if
//  Description : Bus bundle for the instruction fetch unit.
//                Carries three groups of signals:
//                  - the req/ack instruction-memory port
//                  - the valid/ready decode port
//                  - redirect control and the queue occupancy
//                The master modport is the fetch unit side.
//                The slave modport is the memory/decode environment side.
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int XLEN   = 32,
    parameter int QDEPTH = 4
);
    localparam int c_cnt_w = $clog2(QDEPTH) + 1;

    logic               imem_req;
    logic [XLEN-1:0]    imem_addr;
    logic               imem_ack;
    logic [XLEN-1:0]    imem_rdata;
    logic               inst_valid;
    logic [XLEN-1:0]    inst_data;
    logic [XLEN-1:0]    inst_pc;
    logic               inst_ready;
    logic               redirect;
    logic [XLEN-1:0]    redirect_pc;
    logic [c_cnt_w-1:0] q_count;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready,
        input  redirect, redirect_pc,
        output q_count
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready,
        output redirect, redirect_pc,
        input  q_count
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Instruction fetch stage.
//                - Holds the fetch PC and issues one request at a time over
//                  a req/ack instruction-memory handshake.
//                - Buffers fetched words together with their PCs in a
//                  QDEPTH-entry prefetch queue.
//                - Presents the queue head to decode over valid/ready.
//                - A redirect flushes the queue and restarts fetch; a
//                  request already in flight is drained and its data dropped.
//  Ports       : clk, reset (synchronous, active-high)
//                bus.master : imem_req/imem_addr/imem_ack/imem_rdata,
//                             inst_valid/inst_data/inst_pc/inst_ready,
//                             redirect/redirect_pc, q_count
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    instr_fetch_unit_if.master bus
);
    localparam int c_ptr_w = $clog2(QDEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_wait  = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;

    localparam logic [XLEN-1:0] c_align_mask = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] c_word_step  = XLEN'(4);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [XLEN-1:0]    r_fetch_pc;
    logic [XLEN-1:0]    r_addr;
    logic [XLEN-1:0]    w_fetch_pc_nxt;
    logic [XLEN-1:0]    w_addr_nxt;

    logic [XLEN-1:0]    r_q_data [QDEPTH];
    logic [XLEN-1:0]    r_q_pc   [QDEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;

    logic               w_ack;
    logic               w_pop;
    logic               w_push;
    logic               w_space;
    logic [c_cnt_w-1:0] w_count_next;
    logic [XLEN-1:0]    w_addr_inc;
    logic [XLEN-1:0]    w_redir_pc;

    // An ack only means something while a request is actually outstanding.
    assign w_ack        = (r_state != c_idle) && bus.imem_ack;
    // Redirect voids any pop and any push in its cycle.
    assign w_pop        = (r_count != '0) && bus.inst_ready && !bus.redirect;
    assign w_push       = (r_state == c_wait) && w_ack && !bus.redirect;
    assign w_count_next = bus.redirect ? '0
                        : (r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop));
    // Space check uses next-cycle occupancy so a pop can open a slot for an
    // issue in the same cycle.
    assign w_space      = (w_count_next < c_cnt_w'(QDEPTH));
    assign w_addr_inc   = r_addr + c_word_step;
    assign w_redir_pc   = bus.redirect_pc & c_align_mask;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (!bus.redirect && w_space) begin
                    w_state_nxt = c_wait;
                end
            end
            c_wait: begin
                if (bus.redirect) begin
                    // Data acked in the redirect cycle is simply dropped.
                    w_state_nxt = w_ack ? c_idle : c_drain;
                end else if (w_ack) begin
                    w_state_nxt = w_space ? c_wait : c_idle;
                end
            end
            c_drain: begin
                if (w_ack) begin
                    w_state_nxt = w_space ? c_wait : c_idle;
                end
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Request address / fetch PC update
    // ------------------------------------------------------------------
    always_comb begin
        w_fetch_pc_nxt = r_fetch_pc;
        w_addr_nxt     = r_addr;
        if (bus.redirect) begin
            w_fetch_pc_nxt = w_redir_pc;
        end
        case (r_state)
            c_idle: begin
                if (!bus.redirect && w_space) begin
                    w_addr_nxt = r_fetch_pc;
                end
            end
            c_wait: begin
                if (!bus.redirect && w_ack) begin
                    w_fetch_pc_nxt = w_addr_inc;
                    if (w_space) begin
                        w_addr_nxt = w_addr_inc;
                    end
                end
            end
            c_drain: begin
                // A redirect landing with the draining ack wins the new issue.
                if (w_ack && w_space) begin
                    w_addr_nxt = w_fetch_pc_nxt;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers and prefetch queue
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_fetch_pc <= w_fetch_pc_nxt;
            r_addr     <= w_addr_nxt;
            r_count    <= w_count_next;
            if (bus.redirect) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                if (w_push) begin
                    r_q_data[r_tail] <= bus.imem_rdata;
                    r_q_pc[r_tail]   <= r_addr;
                    r_tail           <= r_tail + 1'b1;
                end
                if (w_pop) begin
                    r_head <= r_head + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all decoded from registers
    // ------------------------------------------------------------------
    assign bus.imem_req   = (r_state != c_idle);
    assign bus.imem_addr  = r_addr;
    assign bus.inst_valid = (r_count != '0);
    assign bus.inst_data  = (r_count != '0) ? r_q_data[r_head] : '0;
    assign bus.inst_pc    = (r_count != '0) ? r_q_pc[r_head]   : '0;
    assign bus.q_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit.
//                The reference model tracks the architectural fetch stream:
//                the next PC to fetch and whether the in-flight request is
//                stale after a redirect. Every fetch the memory completes
//                pushes {pc, word} into a scoreboard queue. A separate
//                negedge monitor compares the queue head offered to decode,
//                the occupancy and the idle-output zeros.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;
    localparam int          XLEN     = 32;
    localparam int          QDEPTH   = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.XLEN(XLEN), .QDEPTH(QDEPTH)) bus ();

    instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_pops   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] model_pc = RESET_PC;
    bit          pending  = 1'b0;
    bit          cyc_push = 1'b0;
    bit          cyc_skip = 1'b1;
    bit          mon_en   = 1'b0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h0000_00A5;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, got, want, $time);
    endtask

    // Called just after a rising edge; drives one cycle of inputs, advances
    // the model for what the coming edge must do, then waits for that edge.
    task automatic step(input bit a, input bit r, input bit rd,
                        input logic [31:0] rpc, input bit rs);
        cyc_push        = 1'b0;
        cyc_skip        = rd | rs;
        reset           = rs;
        bus.inst_ready  = r;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.imem_ack    = a;
        bus.imem_rdata  = word_of(bus.imem_addr);
        if (rs) begin
            exp_q.delete();
            model_pc = RESET_PC;
            pending  = 1'b0;
        end else if (rd) begin
            exp_q.delete();
            model_pc = rpc & 32'hFFFF_FFFC;
            // Whatever is in flight is stale; an ack now consumes it.
            if (bus.imem_req) pending = !a;
        end else if (bus.imem_req && a) begin
            if (pending) begin
                pending = 1'b0;
            end else begin
                check("imem_addr", bus.imem_addr, model_pc);
                exp_q.push_back({model_pc, word_of(model_pc)});
                model_pc = model_pc + 32'd4;
                cyc_push = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares what the DUT presents to decode.
    always @(negedge clk) begin
        if (mon_en) begin
            int          exp_cnt;
            logic [63:0] e;
            exp_cnt = exp_q.size() - int'(cyc_push);
            if (!cyc_skip) begin
                check("q_count", 32'(bus.q_count), 32'(exp_cnt));
                check("inst_valid", 32'(bus.inst_valid), 32'(exp_cnt != 0));
            end
            if (!bus.inst_valid) begin
                check("idle_data", bus.inst_data, 32'h0);
                check("idle_pc", bus.inst_pc, 32'h0);
            end else if (bus.inst_ready && !bus.redirect && !reset) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop_pc", bus.inst_pc, 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    check("inst_pc", bus.inst_pc, e[63:32]);
                    check("inst_data", bus.inst_data, e[31:0]);
                    n_pops++;
                end
            end
        end
    end

    initial begin
        logic [31:0] saved;
        int          p0;
        int          guard;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(bus.imem_req), 32'h0);
        check("rst_addr", bus.imem_addr, RESET_PC);
        check("rst_valid", 32'(bus.inst_valid), 32'h0);
        check("rst_count", 32'(bus.q_count), 32'h0);
        check("rst_data", bus.inst_data, 32'h0);
        check("rst_pc", bus.inst_pc, 32'h0);
        mon_en = 1'b1;
        step(0, 0, 0, 0, 0);
        check("first_req", 32'(bus.imem_req), 32'h1);
        check("first_addr", bus.imem_addr, RESET_PC);

        // 1: streaming, one instruction per cycle
        p0 = n_pops;
        repeat (20) step(1, 1, 0, 0, 0);
        check("stream_rate", 32'(n_pops - p0 >= 17), 32'h1);

        // 2: fill with decode stalled, then drain
        repeat (8) step(1, 0, 0, 0, 0);
        check("full_count", 32'(bus.q_count), 32'd4);
        check("full_req_low", 32'(bus.imem_req), 32'h0);
        repeat (8) step(1, 1, 0, 0, 0);

        // 3: redirect while a request is pending
        repeat (3) step(0, 1, 0, 0, 0);
        saved = bus.imem_addr;
        step(0, 1, 1, 32'h0000_0103, 0);
        check("drain_req", 32'(bus.imem_req), 32'h1);
        check("drain_addr", bus.imem_addr, saved);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        check("redir_addr", bus.imem_addr, 32'h0000_0100);
        repeat (6) step(1, 1, 0, 0, 0);

        // 4: full queue, then pop and ack together
        repeat (8) step(1, 0, 0, 0, 0);
        repeat (10) step(1, 1, 0, 0, 0);

        // 5: PC wraps at the top of the address space
        step(0, 1, 1, 32'hFFFF_FFFC, 0);
        repeat (10) step(1, 1, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit          rd;
            logic [31:0] rpc;
            rd  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), rd, rpc, 0);
        end

        // 6: reset mid-WAIT with two entries queued
        step(0, 1, 1, 32'h0000_0040, 0);
        guard = 0;
        while (!(bus.q_count == 2 && bus.imem_req) && guard < 20) begin
            step(1, 0, 0, 0, 0);
            guard++;
        end
        check("pre_rst_count", 32'(bus.q_count), 32'd2);
        step(1, 1, 0, 0, 1);
        check("mid_rst_req", 32'(bus.imem_req), 32'h0);
        check("mid_rst_valid", 32'(bus.inst_valid), 32'h0);
        check("mid_rst_count", 32'(bus.q_count), 32'h0);
        step(0, 1, 0, 0, 0);
        check("refetch_req", 32'(bus.imem_req), 32'h1);
        check("refetch_addr", bus.imem_addr, RESET_PC);
        repeat (10) step(1, 1, 0, 0, 0);

        // Drain what remains
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            step(0, 1, 0, 0, 0);
            guard++;
        end
        step(0, 1, 0, 0, 0);
        check("final_empty", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
